// File: rtl/clk_en_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_gen_pkg
// Shared constants and types for the clock-enable generator.
//   DEF_*       : default parameter values used by clk_en_gen
//   chan_cfg_t  : one channel configuration record {div, phase, en} at the
//                 default divider width
// -----------------------------------------------------------------------------
package clk_en_gen_pkg;

   localparam int DEF_NCH      = 4;
   localparam int DEF_DIVW     = 16;
   localparam int DEF_DIV_VAL  = 50;
   localparam int DEF_LOCK_CNT = 1024;

   typedef struct packed {
      logic [DEF_DIVW-1:0] div;
      logic [DEF_DIVW-1:0] phase;
      logic                en;
   } chan_cfg_t;

endpackage

// File: rtl/clk_en_gen_chan.sv
// -----------------------------------------------------------------------------
// clk_en_chan
// One clock-enable channel: period counter, shadow config and ce strobe.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   run_i        : current lock-qualified run flag (sys_rst_n)
//   run_next_i   : next-cycle value of the run flag
//   sync_i       : restart counter and commit pending config
//   we_i         : config write strobe for this channel
//   div_i/phase_i/en_i : write data
//   ce_o         : one-cycle clock-enable strobe (registered)
//   pending_o    : shadow config waiting for the next wrap
// -----------------------------------------------------------------------------
module clk_en_chan
   import clk_en_gen_pkg::*;
#(
   parameter int DIVW    = DEF_DIVW,
   parameter int DEF_DIV = DEF_DIV_VAL
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run_i,
   input  logic            run_next_i,
   input  logic            sync_i,
   input  logic            we_i,
   input  logic [DIVW-1:0] div_i,
   input  logic [DIVW-1:0] phase_i,
   input  logic            en_i,
   output logic            ce_o,
   output logic            pending_o
);

   logic            en_q, en_d;
   logic [DIVW-1:0] cnt_q, cnt_d;
   logic [DIVW-1:0] div_q, div_d;
   logic [DIVW-1:0] phase_q, phase_d;
   logic [DIVW-1:0] sh_div_q, sh_div_d;
   logic [DIVW-1:0] sh_phase_q, sh_phase_d;
   logic            pend_q, pend_d;
   logic            ce_q, ce_d;

   logic            active, wrap, eff_pend;
   logic [DIVW-1:0] wr_div, wr_phase, eff_div, eff_phase;

   // Sanitised write data: div 0 acts as 1, phase clamped into the new period.
   assign wr_div   = (div_i == '0) ? DIVW'(1) : div_i;
   assign wr_phase = (phase_i >= wr_div) ? wr_div - 1'b1 : phase_i;

   assign active = en_q & run_i;
   assign wrap   = (cnt_q >= div_q - 1'b1);

   always_comb begin
      en_d       = en_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      phase_d    = phase_q;
      sh_div_d   = sh_div_q;
      sh_phase_d = sh_phase_q;
      pend_d     = pend_q;

      // A write arriving on a commit cycle wins over older shadow contents.
      eff_div   = we_i ? wr_div   : sh_div_q;
      eff_phase = we_i ? wr_phase : sh_phase_q;
      eff_pend  = pend_q | we_i;

      if (we_i) begin
         en_d = en_i;
      end

      if (!active) begin
         cnt_d  = '0;
         pend_d = 1'b0;
         if (eff_pend) begin
            div_d   = eff_div;
            phase_d = eff_phase;
         end
      end else begin
         cnt_d = (sync_i || wrap) ? '0 : cnt_q + 1'b1;
         if ((sync_i || wrap) && eff_pend) begin
            div_d   = eff_div;
            phase_d = eff_phase;
            pend_d  = 1'b0;
         end else if (we_i) begin
            sh_div_d   = wr_div;
            sh_phase_d = wr_phase;
            pend_d     = 1'b1;
         end
      end

      // Suppress the strobe if the channel will be inactive when it appears.
      ce_d = active & en_d & run_next_i & (cnt_q == phase_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q       <= 1'b0;
         cnt_q      <= '0;
         div_q      <= DIVW'(DEF_DIV);
         phase_q    <= '0;
         sh_div_q   <= DIVW'(DEF_DIV);
         sh_phase_q <= '0;
         pend_q     <= 1'b0;
         ce_q       <= 1'b0;
      end else begin
         en_q       <= en_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         phase_q    <= phase_d;
         sh_div_q   <= sh_div_d;
         sh_phase_q <= sh_phase_d;
         pend_q     <= pend_d;
         ce_q       <= ce_d;
      end
   end

   assign ce_o      = ce_q;
   assign pending_o = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Lock-qualified reset generator plus NCH programmable clock-enable channels.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   locked       : PLL lock flag (asynchronous, synchronised here)
//   sync_all     : restart all active channels together
//   cfg_we/cfg_ch/cfg_div/cfg_phase/cfg_en : channel configuration write
//   sys_rst_n    : lock-qualified active-low reset for downstream logic
//   ce           : per-channel clock-enable strobes
//   cfg_pending  : per-channel "config waiting for wrap" flags
// -----------------------------------------------------------------------------
module clk_en_gen
   import clk_en_gen_pkg::*;
#(
   parameter int NCH      = DEF_NCH,
   parameter int DIVW     = DEF_DIVW,
   parameter int DEF_DIV  = DEF_DIV_VAL,
   parameter int LOCK_CNT = DEF_LOCK_CNT,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            locked,
   input  logic            sync_all,
   input  logic            cfg_we,
   input  logic [CHW-1:0]  cfg_ch,
   input  logic [DIVW-1:0] cfg_div,
   input  logic [DIVW-1:0] cfg_phase,
   input  logic            cfg_en,
   output logic            sys_rst_n,
   output logic [NCH-1:0]  ce,
   output logic [NCH-1:0]  cfg_pending
);

   localparam int LCW = $clog2(LOCK_CNT + 1);

   logic           lock_s1_q, lock_s2_q;
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
   logic           sys_rst_n_q, sys_rst_n_d;

   // Lock count saturates at LOCK_CNT; release follows one cycle after.
   always_comb begin
      lock_cnt_d  = lock_cnt_q;
      sys_rst_n_d = sys_rst_n_q;
      if (!lock_s2_q) begin
         lock_cnt_d  = '0;
         sys_rst_n_d = 1'b0;
      end else begin
         if (lock_cnt_q != LCW'(LOCK_CNT)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
         end
         if (lock_cnt_q == LCW'(LOCK_CNT)) begin
            sys_rst_n_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_s1_q   <= 1'b0;
         lock_s2_q   <= 1'b0;
         lock_cnt_q  <= '0;
         sys_rst_n_q <= 1'b0;
      end else begin
         lock_s1_q   <= locked;
         lock_s2_q   <= lock_s1_q;
         lock_cnt_q  <= lock_cnt_d;
         sys_rst_n_q <= sys_rst_n_d;
      end
   end

   assign sys_rst_n = sys_rst_n_q;

   // Channel indices >= NCH match no instance, so such writes are dropped.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      clk_en_chan #(
         .DIVW    (DIVW),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .run_i      (sys_rst_n_q),
         .run_next_i (sys_rst_n_d),
         .sync_i     (sync_all),
         .we_i       (cfg_we && (cfg_ch == CHW'(gi))),
         .div_i      (cfg_div),
         .phase_i    (cfg_phase),
         .en_i       (cfg_en),
         .ce_o       (ce[gi]),
         .pending_o  (cfg_pending[gi])
      );
   end

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;
   import clk_en_gen_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, locked, sync_all, cfg_we, cfg_en;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_div, cfg_phase;
   logic        sys_rst_n;
   logic [3:0]  ce, cfg_pending;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   clk_en_gen #(
      .NCH      (4),
      .DIVW     (16),
      .DEF_DIV  (50),
      .LOCK_CNT (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .locked      (locked),
      .sync_all    (sync_all),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_div     (cfg_div),
      .cfg_phase   (cfg_phase),
      .cfg_en      (cfg_en),
      .sys_rst_n   (sys_rst_n),
      .ce          (ce),
      .cfg_pending (cfg_pending)
   );

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic chan_cfg_t mk(input int d, input int p, input bit e);
      chan_cfg_t c;
      c.div   = 16'(d);
      c.phase = 16'(p);
      c.en    = e;
      return c;
   endfunction

   task automatic drive_cfg(input int ch, input chan_cfg_t c);
      cfg_we    = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = c.div;
      cfg_phase = c.phase;
      cfg_en    = c.en;
      $display("cfg write ch%0d div=%0d phase=%0d en=%0d", ch, c.div, c.phase, c.en);
   endtask

   task automatic idle;
      cfg_we   = 1'b0;
      sync_all = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; locked = 1'b0; idle();
      cfg_ch = '0; cfg_div = '0; cfg_phase = '0; cfg_en = 1'b0;
      repeat (3) tick();
      checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n got %b expected 0", sys_rst_n); end
      checks++; if (ce !== 4'b0) begin errors++; $display("FAIL reset_ce got %b expected 0000", ce); end
      checks++; if (cfg_pending !== 4'b0) begin errors++; $display("FAIL reset_pending got %b expected 0000", cfg_pending); end
      rst_n = 1'b1;
      repeat (4) tick();
      checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL unlocked_sys_rst_n got %b expected 0", sys_rst_n); end
      $display("reset done");
   endtask

   task automatic test_lock;
      logic exp;
      locked = 1'b1;
      for (int k = 1; k <= 52; k++) begin
         tick();
         exp = ((k >= 19) && (k <= 32)) || (k >= 50);
         checks++;
         if (sys_rst_n !== exp) begin
            errors++; $display("FAIL lock_sys_rst_n cycle %0d got %b expected %b", k, sys_rst_n, exp);
         end
         if (k == 30) locked = 1'b0;
         if (k == 31) locked = 1'b1;
      end
      $display("lock qualification sequence done");
   endtask

   task automatic test_basic;
      logic exp;
      drive_cfg(0, mk(4, 0, 1'b1));
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) idle();
         exp = (k >= 2) && ((k - 2) % 4 == 0);
         checks++;
         if (ce[0] !== exp) begin
            errors++; $display("FAIL basic_ce0 cycle %0d got %b expected %b", k, ce[0], exp);
         end
         checks++;
         if (cfg_pending[0] !== 1'b0) begin
            errors++; $display("FAIL basic_pending0 cycle %0d got %b expected 0", k, cfg_pending[0]);
         end
      end
   endtask

   task automatic test_pending;
      logic exp_ce, exp_p;
      drive_cfg(1, mk(5, 0, 1'b1));
      for (int k = 1; k <= 22; k++) begin
         tick();
         exp_ce = (k == 2) || (k == 7) || (k == 12) || (k == 15) || (k == 18) || (k == 21);
         exp_p  = (k == 9) || (k == 10);
         checks++;
         if (ce[1] !== exp_ce) begin
            errors++; $display("FAIL pending_ce1 cycle %0d got %b expected %b", k, ce[1], exp_ce);
         end
         checks++;
         if (cfg_pending[1] !== exp_p) begin
            errors++; $display("FAIL pending_flag1 cycle %0d got %b expected %b", k, cfg_pending[1], exp_p);
         end
         if (k == 1)  idle();
         if (k == 8)  drive_cfg(1, mk(7, 0, 1'b1));
         if (k == 9)  drive_cfg(1, mk(3, 0, 1'b1));
         if (k == 10) idle();
      end
   endtask

   task automatic test_sync;
      logic exp0, exp1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k >= 4) begin
            exp0 = (k >= 5) && ((k - 5) % 4 == 0);
            exp1 = (k >= 7) && ((k - 7) % 4 == 0);
            checks++;
            if (ce[0] !== exp0) begin
               errors++; $display("FAIL sync_ce0 cycle %0d got %b expected %b", k, ce[0], exp0);
            end
            checks++;
            if (ce[1] !== exp1) begin
               errors++; $display("FAIL sync_ce1 cycle %0d got %b expected %b", k, ce[1], exp1);
            end
            checks++;
            if (cfg_pending[1:0] !== 2'b00) begin
               errors++; $display("FAIL sync_pending cycle %0d got %b expected 00", k, cfg_pending[1:0]);
            end
         end
         if (k == 1) drive_cfg(0, mk(4, 1, 1'b1));
         if (k == 2) begin
            drive_cfg(1, mk(4, 3, 1'b1));
            sync_all = 1'b1;
            $display("sync_all pulse");
         end
         if (k == 3) idle();
      end
   endtask

   task automatic test_div0;
      logic exp3;
      drive_cfg(2, mk(0, 9, 1'b1));
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp3 = (k >= 6) && ((k - 6) % 4 == 0);
         checks++;
         if (ce[2] !== (k >= 2)) begin
            errors++; $display("FAIL div0_ce2 cycle %0d got %b expected %b", k, ce[2], (k >= 2));
         end
         checks++;
         if (ce[3] !== exp3) begin
            errors++; $display("FAIL clamp_ce3 cycle %0d got %b expected %b", k, ce[3], exp3);
         end
         checks++;
         if (cfg_pending[3:2] !== 2'b00) begin
            errors++; $display("FAIL div0_pending cycle %0d got %b expected 00", k, cfg_pending[3:2]);
         end
         if (k == 1) drive_cfg(3, mk(4, 9, 1'b1));
         if (k == 2) idle();
      end
   endtask

   task automatic test_disable;
      drive_cfg(2, mk(1, 0, 1'b0));
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (k == 1) idle();
         checks++;
         if (ce[2] !== 1'b0) begin
            errors++; $display("FAIL disable_ce2 cycle %0d got %b expected 0", k, ce[2]);
         end
      end
   endtask

   task automatic test_reset_mid;
      int waited;
      sync_all = 1'b1;
      $display("sync_all pulse");
      tick();
      idle();
      drive_cfg(3, mk(6, 2, 1'b1));
      tick();
      checks++;
      if (cfg_pending[3] !== 1'b1) begin
         errors++; $display("FAIL midrst_pending_before got %b expected 1", cfg_pending[3]);
      end
      rst_n = 1'b0;
      drive_cfg(0, mk(2, 0, 1'b1));
      tick();
      checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_sys_rst_n got %b expected 0", sys_rst_n); end
      checks++; if (ce !== 4'b0) begin errors++; $display("FAIL midrst_ce got %b expected 0000", ce); end
      checks++; if (cfg_pending !== 4'b0) begin errors++; $display("FAIL midrst_pending got %b expected 0000", cfg_pending); end
      rst_n = 1'b1;
      idle();
      waited = 0;
      while (sys_rst_n !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      checks++;
      if (sys_rst_n !== 1'b1) begin
         errors++; $display("FAIL midrst_relock_timeout got %b expected 1 within 40 cycles", sys_rst_n);
      end
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if ((ce !== 4'b0) || (cfg_pending !== 4'b0)) begin
            errors++; $display("FAIL postrst_idle cycle %0d got ce=%b pending=%b expected 0000/0000", k, ce, cfg_pending);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_basic();
      test_pending();
      test_sync();
      test_div0();
      test_disable();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter NCH, default 4: number of clock-enable channels, 1..16.
REQ-002 SHALL have parameter DIVW, default 16: divider/phase width in bits.
REQ-003 SHALL have parameter DEF_DIV, default 50: divider loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CNT, default 1024: cycles of continuous lock required before reset release.
REQ-005 clk  input  1  sole clock, typically the PLL clkout0.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 locked  input  1  PLL lock flag, asynchronous to clk.
REQ-008 sync_all  input  1  one-cycle pulse; restarts all active channel counters together.
REQ-009 cfg_we  input  1  configuration write strobe.
REQ-010 cfg_ch  input  $clog2(NCH) (min 1)  target channel of the write.
REQ-011 cfg_div  input  DIVW  new period in cycles; 0 is treated as 1.
REQ-012 cfg_phase  input  DIVW  new phase offset; values >= div are clamped to div-1.
REQ-013 cfg_en  input  1  new channel enable.
REQ-014 sys_rst_n  output  1  lock-qualified reset for downstream logic, active-low.
REQ-015 ce  output  NCH  per-channel one-cycle clock-enable strobes.
REQ-016 cfg_pending  output  NCH  a written div/phase is waiting for channel wrap.

Function
REQ-017 SHALL pass locked through a 2-flop synchroniser before any use.
REQ-018 SHALL count consecutive cycles of synchronised lock high; the count SHALL reset to 0 on any low cycle.
REQ-019 SHALL drive sys_rst_n high on the cycle after the count reaches LOCK_CNT, then hold it high while lock stays high.
REQ-020 SHALL drive sys_rst_n low on the cycle after synchronised lock falls.
REQ-021 A channel SHALL be active only when its enable bit is 1 and sys_rst_n is 1; an inactive channel SHALL hold its counter at 0 and its ce at 0.
REQ-022 An active channel SHALL count 0..div-1 and wrap to 0.
REQ-023 ce[i] SHALL be a registered output, high in the cycle after counter == phase, giving exactly one pulse per div cycles.
REQ-024 With div 1, ce[i] SHALL be continuously high while the channel is active.
REQ-025 cfg_we SHALL update the enable bit immediately, on the next cycle.
REQ-026 On an active channel, cfg_we SHALL latch div/phase into shadow registers, set cfg_pending[i], and commit them on the cycle the counter wraps, so no period is shortened or doubled.
REQ-027 On an inactive channel, cfg_we SHALL commit div/phase immediately and SHALL NOT set cfg_pending[i].
REQ-028 A second cfg_we to a channel with pending config SHALL overwrite the shadow registers; only the last write is committed.
REQ-029 sync_all SHALL zero every active counter on the next cycle and commit all pending configs at the same time.
REQ-030 A channel going from inactive to active SHALL start with counter 0 on its first active cycle.
REQ-031 When sync_all and cfg_we coincide, the write SHALL apply first and the restart SHALL use the new values.
REQ-032 cfg_ch >= NCH SHALL be ignored.

Reset
REQ-033 On rst_n low, the block SHALL set: sys_rst_n 0, lock count 0, synchroniser 0, ce 0, cfg_pending 0, all counters 0, all enables 0, div DEF_DIV, phase 0.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-035 A shared package SHALL hold the default-width constants and a typedef for channel configuration {div, phase, en}.
REQ-036 The block SHALL use one sub-module, clk_en_chan (counter, shadow registers, ce logic), instantiated NCH times by a generate loop.
REQ-037 The lock qualifier and synchroniser SHALL stay in the top level.

Verification
REQ-038 LOCK_CNT=16, locked rises at cycle 0 -> sys_rst_n rises at cycle 19; a 1-cycle locked drop at cycle 30 -> sys_rst_n low at cycle 33, high again 19 cycles after lock returns.
REQ-039 Ch0 write div=4, phase=0, en=1 with sys_rst_n high at cycle 0 -> ce[0] at cycles 2, 6, 10, ...
REQ-040 Ch1 running div=5; write div=3 mid-period -> cfg_pending[1]=1 until wrap; last 5-cycle period completes, then 3-cycle spacing.
REQ-041 Ch0 div=4 phase=1, ch1 div=4 phase=3, sync_all -> strobes on both channels exactly 2 cycles apart, repeating every 4.
REQ-042 div=0 and phase=9 with div=4 -> ce continuous, and phase behaves as 3.
REQ-043 rst_n low mid-period with pending config -> all outputs at reset values next cycle, pending config discarded.
